// File: rtl/password_setting_if.sv
// Bus bundle for the password-setting block: key/control strobes in,
// stored password, entry display and status out, plus a state debug tap.
interface password_setting_if;
   logic        set;
   logic        check;
   logic        confirm;
   logic        keyboard_en;
   logic [3:0]  keyboard_num;
   logic        boom;
   logic [11:0] setnum;
   logic [11:0] entrynum;
   logic [2:0]  seats;
   logic        setting;
   logic        setend;
   logic [2:0]  state_dbg;

   // Strobes are single-cycle pulses sampled on the rising clock edge; there is
   // no ready/backpressure, every pulse is consumed in the cycle it is seen.
   modport master (
      output set, check, confirm, keyboard_en, keyboard_num, boom,
      input  setnum, entrynum, seats, setting, setend, state_dbg
   );

   modport slave (
      input  set, check, confirm, keyboard_en, keyboard_num, boom,
      output setnum, entrynum, seats, setting, setend, state_dbg
   );
endinterface

// File: rtl/password_setting.sv
// Three-digit BCD password entry: collects digits into a display buffer and
// commits them to the stored password on confirm once all three are present.
module password_setting (
   input  logic               clk,
   input  logic               rst,
   password_setting_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S0   = 3'd1,
      S1   = 3'd2,
      S2   = 3'd3,
      S3   = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [11:0] BLANK_ENTRY = 12'hEEE;
   localparam logic [2:0]  ALL_EMPTY   = 3'b111;

   state_t      state_q,    state_d;
   logic [11:0] setnum_q,   setnum_d;
   logic [11:0] entrynum_q, entrynum_d;
   logic [2:0]  seats_q,    seats_d;
   logic        setting_q,  setting_d;
   logic        setend_q,   setend_d;

   logic        digit_ok;

   assign digit_ok = bus.keyboard_en && (bus.keyboard_num <= 4'd9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         setnum_q   <= 12'h000;
         entrynum_q <= BLANK_ENTRY;
         seats_q    <= ALL_EMPTY;
         setting_q  <= 1'b0;
         setend_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         setnum_q   <= setnum_d;
         entrynum_q <= entrynum_d;
         seats_q    <= seats_d;
         setting_q  <= setting_d;
         setend_q   <= setend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      setnum_d   = setnum_q;
      entrynum_d = entrynum_q;
      seats_d    = seats_q;
      setend_d   = setend_q;

      // Alarm outranks everything, including a fresh set request.
      if (bus.boom) begin
         state_d    = IDLE;
         entrynum_d = BLANK_ENTRY;
         seats_d    = ALL_EMPTY;
         setend_d   = 1'b0;
      end else if (bus.set) begin
         state_d    = S0;
         entrynum_d = BLANK_ENTRY;
         seats_d    = ALL_EMPTY;
         setend_d   = 1'b0;
      end else if (bus.check) begin
         state_d    = IDLE;
         entrynum_d = BLANK_ENTRY;
         seats_d    = ALL_EMPTY;
         setend_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            S0: begin
               if (bus.confirm) begin
                  state_d    = IDLE;
                  entrynum_d = BLANK_ENTRY;
                  seats_d    = ALL_EMPTY;
               end else if (digit_ok) begin
                  state_d          = S1;
                  entrynum_d[11:8] = bus.keyboard_num;
                  seats_d[2]       = 1'b0;
               end
            end
            S1: begin
               if (bus.confirm) begin
                  state_d    = IDLE;
                  entrynum_d = BLANK_ENTRY;
                  seats_d    = ALL_EMPTY;
               end else if (digit_ok) begin
                  state_d         = S2;
                  entrynum_d[7:4] = bus.keyboard_num;
                  seats_d[1]      = 1'b0;
               end
            end
            S2: begin
               // A simultaneous confirm wins; the digit in that cycle is dropped.
               if (bus.confirm) begin
                  state_d    = IDLE;
                  entrynum_d = BLANK_ENTRY;
                  seats_d    = ALL_EMPTY;
               end else if (digit_ok) begin
                  state_d         = S3;
                  entrynum_d[3:0] = bus.keyboard_num;
                  seats_d[0]      = 1'b0;
               end
            end
            S3: begin
               if (bus.confirm) begin
                  state_d  = DONE;
                  setnum_d = entrynum_q;
                  setend_d = 1'b1;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d    = IDLE;
               entrynum_d = BLANK_ENTRY;
               seats_d    = ALL_EMPTY;
               setend_d   = 1'b0;
            end
         endcase
      end

      setting_d = (state_d == S0) || (state_d == S1) ||
                  (state_d == S2) || (state_d == S3);
   end

   assign bus.setnum    = setnum_q;
   assign bus.entrynum  = entrynum_q;
   assign bus.seats     = seats_q;
   assign bus.setting   = setting_q;
   assign bus.setend    = setend_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_password_setting.sv
// Directed bench for password_setting: each step queues the expected outputs
// and compares them against the DUT just after the following clock edge.
module tb_password_setting;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_S0   = 3'd1;
   localparam logic [2:0] ST_S1   = 3'd2;
   localparam logic [2:0] ST_S2   = 3'd3;
   localparam logic [2:0] ST_S3   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam int W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // {chk_buf, state, setnum, entrynum, seats, setend}
   logic [W-1:0] exp_q[$];

   password_setting_if bus_if ();

   password_setting dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus_if.set          = 1'b0;
      bus_if.check        = 1'b0;
      bus_if.confirm      = 1'b0;
      bus_if.keyboard_en  = 1'b0;
      bus_if.keyboard_num = 4'd0;
      bus_if.boom         = 1'b0;
   endtask

   task automatic push_exp(input logic chk_buf, input logic [2:0] st, input logic [11:0] sn,
                           input logic [11:0] en, input logic [2:0] se, input logic sd);
      exp_q.push_back({chk_buf, st, sn, en, se, sd});
   endtask

   task automatic compare_outputs(input string tag);
      logic [W-1:0] e;
      logic         chk_buf;
      logic [2:0]   e_st;
      logic [11:0]  e_sn;
      logic [11:0]  e_en;
      logic [2:0]   e_se;
      logic         e_sd;
      logic         e_setting;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         {chk_buf, e_st, e_sn, e_en, e_se, e_sd} = e;
         e_setting = (e_st == ST_S0) || (e_st == ST_S1) || (e_st == ST_S2) || (e_st == ST_S3);
         check_val({tag, "_state"},   {9'd0, bus_if.state_dbg}, {9'd0, e_st});
         check_val({tag, "_setnum"},  bus_if.setnum,            e_sn);
         check_val({tag, "_setting"}, {11'd0, bus_if.setting},  {11'd0, e_setting});
         if (chk_buf) begin
            check_val({tag, "_entrynum"}, bus_if.entrynum,          e_en);
            check_val({tag, "_seats"},    {9'd0, bus_if.seats},     {9'd0, e_se});
            check_val({tag, "_setend"},   {11'd0, bus_if.setend},   {11'd0, e_sd});
         end
      end
   endtask

   // driver: one clock of stimulus, expected outputs checked after the edge
   task automatic step(input string tag, input logic s, input logic c, input logic cf,
                       input logic ke, input logic [3:0] kn, input logic bm,
                       input logic chk_buf, input logic [2:0] st, input logic [11:0] sn,
                       input logic [11:0] en, input logic [2:0] se, input logic sd);
      @(negedge clk);
      bus_if.set          = s;
      bus_if.check        = c;
      bus_if.confirm      = cf;
      bus_if.keyboard_en  = ke;
      bus_if.keyboard_num = kn;
      bus_if.boom         = bm;
      push_exp(chk_buf, st, sn, en, se, sd);
      @(posedge clk);
      #1;
      compare_outputs(tag);
      clear_inputs();
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      push_exp(1'b1, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 1'b0);
      compare_outputs(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();
      #3;
      push_exp(1'b1, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 1'b0);
      compare_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // full entry and commit of 371
      step("set",        1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("key3",       0,0,0,1,4'd3,0, 1, ST_S1,   12'h000, 12'h3EE, 3'b011, 0);
      step("key7",       0,0,0,1,4'd7,0, 1, ST_S2,   12'h000, 12'h37E, 3'b001, 0);
      step("key1",       0,0,0,1,4'd1,0, 1, ST_S3,   12'h000, 12'h371, 3'b000, 0);
      step("commit",     0,0,1,0,4'd0,0, 1, ST_DONE, 12'h371, 12'h371, 3'b000, 1);
      step("done_conf",  0,0,1,0,4'd0,0, 1, ST_DONE, 12'h371, 12'h371, 3'b000, 1);
      step("done_key",   0,0,0,1,4'd2,0, 1, ST_DONE, 12'h371, 12'h371, 3'b000, 1);
      // set and check together from DONE
      step("set_check",  1,1,0,0,4'd0,0, 1, ST_S0,   12'h371, 12'hEEE, 3'b111, 0);
      step("check",      0,1,0,0,4'd0,0, 1, ST_IDLE, 12'h371, 12'hEEE, 3'b111, 0);
      step("idle_conf",  0,0,1,0,4'd0,0, 1, ST_IDLE, 12'h371, 12'hEEE, 3'b111, 0);
      step("idle_key",   0,0,0,1,4'd4,0, 1, ST_IDLE, 12'h371, 12'hEEE, 3'b111, 0);

      async_reset("rst_idle");

      // incomplete entry abandoned
      step("ab_set",     1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("ab_key3",    0,0,0,1,4'd3,0, 1, ST_S1,   12'h000, 12'h3EE, 3'b011, 0);
      step("ab_key7",    0,0,0,1,4'd7,0, 1, ST_S2,   12'h000, 12'h37E, 3'b001, 0);
      step("ab_conf",    0,0,1,0,4'd0,0, 1, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 0);

      // confirm and key in the same cycle in S2
      step("cc_set",     1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("cc_key8",    0,0,0,1,4'd8,0, 1, ST_S1,   12'h000, 12'h8EE, 3'b011, 0);
      step("cc_key6",    0,0,0,1,4'd6,0, 1, ST_S2,   12'h000, 12'h86E, 3'b001, 0);
      step("cc_confkey", 0,0,1,1,4'd2,0, 1, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 0);

      // out-of-range keys ignored
      step("iv_set",     1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("iv_key12",   0,0,0,1,4'd12,0,1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("iv_key15",   0,0,0,1,4'd15,0,1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("iv_key5",    0,0,0,1,4'd5,0, 1, ST_S1,   12'h000, 12'h5EE, 3'b011, 0);

      // alarm lockout from S1
      step("boom",       0,0,0,0,4'd0,1, 0, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 0);
      step("boom_set",   1,0,0,0,4'd0,1, 0, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 0);
      step("post_boom",  1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("pb_key2",    0,0,0,1,4'd2,0, 1, ST_S1,   12'h000, 12'h2EE, 3'b011, 0);
      step("pb_check",   0,1,0,0,4'd0,0, 1, ST_IDLE, 12'h000, 12'hEEE, 3'b111, 0);

      // commit, then reset during a second entry
      step("r_set",      1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);
      step("r_key3",     0,0,0,1,4'd3,0, 1, ST_S1,   12'h000, 12'h3EE, 3'b011, 0);
      step("r_key7",     0,0,0,1,4'd7,0, 1, ST_S2,   12'h000, 12'h37E, 3'b001, 0);
      step("r_key1",     0,0,0,1,4'd1,0, 1, ST_S3,   12'h000, 12'h371, 3'b000, 0);
      step("r_commit",   0,0,1,0,4'd0,0, 1, ST_DONE, 12'h371, 12'h371, 3'b000, 1);
      step("r_set2",     1,0,0,0,4'd0,0, 1, ST_S0,   12'h371, 12'hEEE, 3'b111, 0);
      step("r_key9",     0,0,0,1,4'd9,0, 1, ST_S1,   12'h371, 12'h9EE, 3'b011, 0);
      step("r_key0",     0,0,0,1,4'd0,0, 1, ST_S2,   12'h371, 12'h90E, 3'b001, 0);
      step("r_key4",     0,0,0,1,4'd4,0, 1, ST_S3,   12'h371, 12'h904, 3'b000, 0);
      async_reset("rst_mid");

      // first set after reset release is taken on the first edge
      step("first_set",  1,0,0,0,4'd0,0, 1, ST_S0,   12'h000, 12'hEEE, 3'b111, 0);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL queue_drain observed=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
